// File: rtl/muldiv_seq_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 encodings, funct7 tag, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_seq_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MULDIV_FUNC_MUL    = 3'd0,
        MULDIV_FUNC_MULH   = 3'd1,
        MULDIV_FUNC_MULHSU = 3'd2,
        MULDIV_FUNC_MULHU  = 3'd3,
        MULDIV_FUNC_DIV    = 3'd4,
        MULDIV_FUNC_DIVU   = 3'd5,
        MULDIV_FUNC_REM    = 3'd6,
        MULDIV_FUNC_REMU   = 3'd7
    } muldiv_func_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_t;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic func_is_div(input muldiv_func_t f);
        return f[2];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between execute stage and the mul/div sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both request and response; flush kills the in-flight op.
interface muldiv_seq_if #(parameter int XLEN = 32);

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_func;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            busy;

    modport master (
        output flush, req_valid, req_func, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    modport slave (
        input  flush, req_valid, req_func, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );

endinterface

// File: rtl/muldiv_decode.sv
// Decodes opcode/funct3/funct7 into the M-extension flag and the mul/div function.
// Latency: combinational.
// Backpressure: none.
module muldiv_decode
    import muldiv_seq_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output logic         is_muldiv,
    output muldiv_func_t func
);

    assign is_muldiv = (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
    assign func      = muldiv_func_t'(funct3);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div: radix-2 shift-add / restoring divide over XLEN cycles, sign fix-up at the end.
// Latency: XLEN+2 cycles accept-to-resp_valid (1 cycle for div-by-zero/overflow with MULDIV_EARLY_OUT_EN).
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready; flush returns to IDLE.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    logic [CW-1:0]     cnt_q;
    muldiv_func_t      func_q;
    logic              neg_res_q, ovf_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   result_q;

    muldiv_func_t      req_fn;
    logic              req_is_md, accept, early_out;
    logic              a_signed, b_signed, b_zero, req_ovf, req_neg, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;

    muldiv_decode u_decode (
        .opcode    (OPCODE_OP),
        .funct3    (bus.req_func),
        .funct7    (FUNCT7_MULDIV),
        .is_muldiv (req_is_md),
        .func      (req_fn)
    );

    assign bus.req_ready   = (state_q == IDLE) && !bus.flush;
    assign bus.resp_valid  = (state_q == DONE);
    assign bus.resp_result = result_q;
    assign bus.busy        = (state_q != IDLE);
    assign accept          = bus.req_valid && bus.req_ready && req_is_md;
    assign sa              = bus.req_a[XLEN-1];
    assign sb              = bus.req_b[XLEN-1];

    always_comb begin
        a_signed = req_fn inside {MULDIV_FUNC_MULH, MULDIV_FUNC_MULHSU, MULDIV_FUNC_DIV, MULDIV_FUNC_REM};
        b_signed = req_fn inside {MULDIV_FUNC_MULH, MULDIV_FUNC_DIV, MULDIV_FUNC_REM};
        a_mag    = (a_signed && sa) ? -bus.req_a : bus.req_a;
        b_mag    = (b_signed && sb) ? -bus.req_b : bus.req_b;
        b_zero   = (bus.req_b == '0);
        req_ovf  = (req_fn == MULDIV_FUNC_DIV || req_fn == MULDIV_FUNC_REM)
                   && (bus.req_a == INT_MIN) && (&bus.req_b);
        // a zero divisor must leave the all-ones quotient un-negated
        case (req_fn)
            MULDIV_FUNC_MULH:                    req_neg = sa ^ sb;
            MULDIV_FUNC_DIV:                     req_neg = (sa ^ sb) && !b_zero;
            MULDIV_FUNC_MULHSU, MULDIV_FUNC_REM: req_neg = sa;
            default:                             req_neg = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_res;
    assign early_out = func_is_div(req_fn) && (b_zero || req_ovf);
    always_comb begin
        early_res = '0;
        if (req_fn == MULDIV_FUNC_DIV || req_fn == MULDIV_FUNC_DIVU)
            early_res = b_zero ? '1 : bus.req_a;
        else
            early_res = b_zero ? bus.req_a : '0;
    end
`else
    assign early_out = 1'b0;
`endif

    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   rem_sub, quo_fix, rem_fix, fix_res;
    logic [2*XLEN-1:0] acc_step, prod_fix;

    // acc holds {hi product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        rem_sub = rem_sh[XLEN-1:0] - opnd_q;
        if (func_is_div(func_q)) begin
            if (rem_sh >= {1'b0, opnd_q})
                acc_step = {rem_sub, acc_q[XLEN-2:0], 1'b1};
            else
                acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_res_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res  = rem_fix;
        case (func_q)
            MULDIV_FUNC_MUL:                                       fix_res = prod_fix[XLEN-1:0];
            MULDIV_FUNC_MULH, MULDIV_FUNC_MULHSU, MULDIV_FUNC_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MULDIV_FUNC_DIV, MULDIV_FUNC_DIVU:                     fix_res = quo_fix;
            default:                                               fix_res = rem_fix;
        endcase
        if (ovf_q)
            fix_res = (func_q == MULDIV_FUNC_DIV) ? INT_MIN : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = early_out ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            func_q    <= MULDIV_FUNC_MUL;
            neg_res_q <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q     <= CW'(XLEN-1);
                    func_q    <= req_fn;
                    neg_res_q <= req_neg;
                    ovf_q     <= req_ovf;
                    acc_q     <= {{XLEN{1'b0}}, a_mag};
                    opnd_q    <= b_mag;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_out)
                        result_q <= early_res;
`endif
                end
                CALC: begin
                    acc_q <= acc_step;
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CW'(1);
                end
                FIX:     result_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized + directed bench for muldiv_seq against an arithmetic RV32M reference model.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();
    muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // driver-owned expectations
    logic [31:0] exp_result = '0;
    logic [31:0] lit_result = '0;
    int          exp_lat = 0;
    int          drv_tmo = 0;
    bit          expect_resp = 1'b0;
    bit          lit_vld = 1'b0;
    bit          chk_rst = 1'b0;
    bit          chk_idle = 1'b0;

    // monitor-owned state
    int          checks = 0;
    int          errors = 0;
    int          lat_cnt = 0;
    int          seen_tmo = 0;
    bit          rv_prev = 1'b0;
    logic [31:0] res_prev = '0;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
            3'd1: begin p = sa * sb;                 return p[63:32]; end
            3'd2: begin p = sa * ub;                 return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit early;
        early = f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (EARLY_EN && early) ? 1 : XLEN + 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    // single compare process: every negedge, outputs are settled
    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) lat_cnt = 0;
        else lat_cnt++;
        if (drv_tmo != seen_tmo) begin
            chk("wait_timeout", drv_tmo, seen_tmo);
            seen_tmo = drv_tmo;
        end
        if (chk_rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_resp_valid", bus.resp_valid, 0);
            chk("rst_resp_result", bus.resp_result, 0);
        end
        if (chk_idle) begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_req_ready", bus.req_ready, 1);
        end
        if (bus.flush) chk("flush_req_ready", bus.req_ready, 0);
        if (bus.resp_valid) begin
            if (!rv_prev) begin
                chk("resp_expected", 1, expect_resp);
                chk("latency", lat_cnt, exp_lat);
                if (lit_vld) chk("literal_result", bus.resp_result, lit_result);
            end else begin
                chk("result_stable", bus.resp_result, res_prev);
            end
            if (expect_resp) chk("result_vs_model", bus.resp_result, exp_result);
            chk("done_req_ready", bus.req_ready, 0);
            chk("done_busy", bus.busy, 1);
        end
        rv_prev  = bus.resp_valid;
        res_prev = bus.resp_result;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit lv, input logic [31:0] lit);
        int n = 0;
        exp_result   = model(f, a, b);
        exp_lat      = exp_latency(f, a, b);
        expect_resp  = 1'b1;
        lit_vld      = lv;
        lit_result   = lit;
        bus.req_func = f;
        bus.req_a    = a;
        bus.req_b    = b;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 200) begin step(); n++; end
        if (n >= 200) drv_tmo++;
        step();
        bus.req_valid = 1'b0;
        chk_idle = 1'b0;
    endtask

    task automatic wait_resp(input int hold, input bit idle_after);
        int n = 0;
        bus.resp_ready = 1'b0;
        while (!bus.resp_valid && n < 100) begin step(); n++; end
        if (n >= 100) drv_tmo++;
        repeat (hold) step();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk_idle = idle_after;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_func = '0;
        bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
        chk_rst = 1'b1;
        step(); step();
        chk_rst = 1'b0;
        rst_n = 1'b1;
        step();

        do_req(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);       wait_resp(0, 1'b0);
        do_req(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000); wait_resp(0, 1'b0);
        do_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE); wait_resp(1, 1'b0);
        do_req(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF);       wait_resp(0, 1'b0);
        do_req(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);       wait_resp(0, 1'b0);
        do_req(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);       wait_resp(0, 1'b0);
        do_req(3'd5, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF);               wait_resp(0, 1'b0);
        do_req(3'd7, 32'd7, 32'd0, 1'b1, 32'd7);                       wait_resp(2, 1'b0);
        do_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000); wait_resp(0, 1'b0);
        do_req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0);       wait_resp(0, 1'b0);

        // consumer stall for 10 cycles, then an immediate back-to-back request
        do_req(3'd1, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h0);       wait_resp(10, 1'b1);
        do_req(3'd5, 32'hDEAD_BEEF, 32'd13, 1'b0, 32'h0);              wait_resp(0, 1'b0);

        // flush at CALC cycle 5
        do_req(3'd0, 32'd100, 32'd200, 1'b0, 32'h0);
        expect_resp = 1'b0;
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; chk_idle = 1'b1;
        step();
        chk_idle = 1'b0;
        repeat (40) step();

        // flush coincident with req_valid, mid-op and again while idle
        do_req(3'd4, 32'd1000, 32'd7, 1'b0, 32'h0);
        expect_resp = 1'b0;
        repeat (6) step();
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_func = 3'd0;
        step();
        step();
        bus.flush = 1'b0; bus.req_valid = 1'b0; chk_idle = 1'b1;
        step();
        chk_idle = 1'b0;
        repeat (40) step();

        // reset pulsed mid-CALC
        do_req(3'd3, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 32'h0);
        expect_resp = 1'b0;
        repeat (3) step();
        rst_n = 1'b0; chk_rst = 1'b1;
        step();
        chk_rst = 1'b0; rst_n = 1'b1;
        repeat (40) step();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            do_req(f, a, b, 1'b0, 32'h0);
            wait_resp($urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
